fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequences the instruction-fetch datapath: owns the PC and issues one request at a time to
//  instruction memory (req/gnt, then rvalid). Buffers each returned word with its PC in a
//  one-entry output register toward decode (valid/ready). Branch redirects from execute update
//  the PC, flush the output register and squash any in-flight response.
// PARAMETERS
//  XLEN      32            width of PC, address and instruction word
//  RESET_PC  32'h0000_0000 PC value loaded on reset (bits [1:0] must be 0)
// PORTS
//  clk            in   1     single clock; all state updates on posedge
//  rst            in   1     synchronous, active-high reset
//  fetch_en_i     in   1     1 = new requests may be issued; 0 = halt after outstanding completes
//  redirect_i     in   1     branch/jump taken; load redirect_pc_i into PC, flush
//  redirect_pc_i  in   XLEN  redirect target; bits [1:0] ignored (treated as 0)
//  imem_req_o     out  1     request to instruction memory
//  imem_addr_o    out  XLEN  request address (= PC); meaningful only while imem_req_o=1
//  imem_gnt_i     in   1     memory accepted request this cycle (only sampled when imem_req_o=1)
//  imem_rvalid_i  in   1     read data valid; arrives >=1 cycle after gnt; cannot be back-pressured
//  imem_rdata_i   in   XLEN  instruction word, valid with imem_rvalid_i
//  instr_valid_o  out  1     output register holds an instruction for decode
//  instr_o        out  XLEN  instruction word to decode
//  pc_o           out  XLEN  PC of instr_o
//  instr_ready_i  in   1     decode accepts instr_o this cycle (handshake = valid & ready)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, pc=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0;
//   imem_req_o=0 during and after reset until REQ. Reset mid-transaction discards any
//   outstanding response (rvalid arriving after reset, before a new gnt, is ignored).
//  can_issue = !instr_valid_o | instr_ready_i (output slot free or emptied this cycle).
//  imem_req_o = (state==REQ) & fetch_en_i & can_issue & !redirect_i; imem_addr_o = pc (combinational).
//  At most one outstanding request -> response always finds output slot free; no extra buffer.
//  States/transitions (redirect_i has priority over everything else):
//   IDLE: fetch_en_i -> REQ. redirect_i: pc<=redirect_pc.
//   REQ : imem_req_o & imem_gnt_i -> WAIT. !fetch_en_i -> IDLE. redirect_i: pc<=redirect_pc,
//         stay REQ (no req driven that cycle, so no grant to squash).
//   WAIT: imem_rvalid_i & !redirect_i -> load instr_o<=rdata, pc_o<=pc, instr_valid_o<=1,
//         pc<=pc+4 (mod 2^XLEN, wraps FFFF_FFFC->0), next REQ (IDLE if !fetch_en_i).
//         redirect_i & !rvalid -> pc<=redirect_pc, -> DROP. redirect_i & rvalid -> data
//         discarded, pc<=redirect_pc, -> REQ.
//   DROP: wait for stale response; imem_rvalid_i -> discard, -> REQ. redirect_i: pc<=redirect_pc,
//         stay DROP (or -> REQ if rvalid same cycle).
//  Output register: cleared (instr_valid_o<=0) on valid&ready or on redirect_i in any state;
//   a redirect flush wins over a same-cycle load. Holds instr_o/pc_o stable while valid & !ready.
//  Latency: gnt in cycle t, rvalid in t+k (k>=1) -> instr_valid_o=1 from t+k+1. Peak throughput
//   one instruction per 2 cycles (REQ, WAIT with k=1).
//  fetch_en_i=0 never aborts a granted request; WAIT/DROP complete normally first.
//  pc[1:0] are always 0.
// TESTING
//  1 Reset: rst=1 two cycles, fetch_en_i=0 -> imem_req_o=0, instr_valid_o=0, pc=RESET_PC; then
//    fetch_en_i=1 -> imem_req_o=1, imem_addr_o=0x0 next cycle.
//  2 Stream: gnt immediate, rvalid 1 cycle later, rdata=0x13,0x93,0x113, ready=1 -> decode sees
//    (pc,instr)=(0x0,0x13),(0x4,0x93),(0x8,0x113), one per 2 cycles.
//  3 Back-pressure: ready=0 for 5 cycles after first instr -> instr_o/pc_o held, imem_req_o=0;
//    ready=1 -> same-cycle request for 0x4.
//  4 Redirect in WAIT (rvalid 3 cycles after gnt): redirect_pc=0x100 -> DROP, stale word not
//    delivered, next imem_addr_o=0x100, delivered pc_o=0x100.
//  5 Redirect same cycle as rvalid and with instr_valid_o=1 -> output flushed, data dropped,
//    next request 0x100; also pc wrap: RESET_PC=0xFFFF_FFFC -> second fetch address 0x0.
//  6 fetch_en_i=0 in WAIT -> response delivered, then IDLE with imem_req_o=0; rst mid-WAIT ->
//    late rvalid ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight and
// buffers the returned word with its PC in a single output register toward decode.
module fetch_ctrl #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic            load_s;
  logic            can_issue_s;
  logic            req_s;
  logic [XLEN-1:0] redir_pc_s;
  logic [XLEN-1:0] pc_inc_s;

  assign redir_pc_s  = redirect_pc_i & ALIGN_MASK;
  assign pc_inc_s    = pc_q + PC_STEP;
  // A request is only issued when the response is guaranteed a free output slot.
  assign can_issue_s = ~valid_q | instr_ready_i;
  assign req_s       = (state_q == REQ) & fetch_en_i & can_issue_s & ~redirect_i;

  assign imem_req_o    = req_s;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;

  // Next-state, PC and output-register update logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_i) pc_d = redir_pc_s;
        else            pc_d = pc_q;
        if (fetch_en_i) state_d = REQ;
        else            state_d = IDLE;
      end
      REQ: begin
        if (redirect_i)                 pc_d    = redir_pc_s;
        else if (req_s & imem_gnt_i)    state_d = WAIT;
        else if (!fetch_en_i)           state_d = IDLE;
        else                            state_d = REQ;
      end
      WAIT: begin
        if (redirect_i) begin
          pc_d = redir_pc_s;
          if (imem_rvalid_i) state_d = REQ;
          else               state_d = DROP;
        end else if (imem_rvalid_i) begin
          load_s = 1'b1;
          pc_d   = pc_inc_s;
          if (fetch_en_i) state_d = REQ;
          else            state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        // Stale response from before a redirect: swallow it, then resume.
        if (redirect_i) pc_d = redir_pc_s;
        else            pc_d = pc_q;
        if (imem_rvalid_i) state_d = REQ;
        else               state_d = DROP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_i)                    valid_d = 1'b0;
    else if (load_s)                   valid_d = 1'b1;
    else if (valid_q & instr_ready_i)  valid_d = 1'b0;
    else                               valid_d = valid_q;

    if (load_s & ~redirect_i) begin
      instr_d  = imem_rdata_i;
      pc_out_d = pc_q;
    end else begin
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

endmodule
